// File: rtl/vga_timing_pkg.sv
// Shared raster timing constants for the VGA path: default 640x480@60 timing,
// sync polarity constants and helpers to derive the line/frame totals.
package vga_timing_pkg;

  localparam int CNT_W        = 10;
  localparam int MAX_TOTAL    = 1 << CNT_W;
  localparam int MAX_PIPE_DLY = 4;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;

  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  // Asserted level of hsync/vsync; 640x480 VGA uses active-low sync.
  localparam bit SYNC_ACTIVE_LOW  = 1'b0;
  localparam bit SYNC_ACTIVE_HIGH = 1'b1;

  // The two sync lines travel together through the delay pipeline.
  typedef struct packed {
    logic hsync;
    logic vsync;
  } sync_t;

  function automatic int h_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int v_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_timing_gen_sync_delay_line.sv
// Reset-clearable shift register used to align hsync/vsync with the
// registered RGB stage downstream. DEPTH=0 is a plain wire.
module sync_delay_line #(
  parameter int               WIDTH   = 2,
  parameter int               DEPTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  if (DEPTH == 0) begin : g_pass
    // Clock and reset have no load in the pass-through build.
    logic unused_pass;
    assign unused_pass = clk ^ rst_n;
    assign dout = din;
  end else begin : g_shift
    logic [WIDTH-1:0] stage [DEPTH];

    // Every stage is cleared on reset so nothing stale can emerge afterwards.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        for (int i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
      end else begin
        stage[0] <= din;
        for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
    end

    assign dout = stage[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing source: pixel/line counters, registered coordinates and
// active-video flag, sync generation with a configurable alignment delay,
// a frame start strobe and a wrapping frame counter.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  parameter bit SYNC_POL = SYNC_ACTIVE_LOW,
  parameter int PIPE_DLY = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             frame_active,
  output logic             hsync,
  output logic             vsync,
  output logic             frame_start,
  output logic [7:0]       frame_count
);

  localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  if (H_TOTAL > MAX_TOTAL) begin : g_err_h_total
    $error("vga_timing_gen: H_TOTAL %0d exceeds %0d", H_TOTAL, MAX_TOTAL);
  end
  if (V_TOTAL > MAX_TOTAL) begin : g_err_v_total
    $error("vga_timing_gen: V_TOTAL %0d exceeds %0d", V_TOTAL, MAX_TOTAL);
  end
  if (PIPE_DLY < 0 || PIPE_DLY > MAX_PIPE_DLY) begin : g_err_pipe_dly
    $error("vga_timing_gen: PIPE_DLY %0d outside 0..%0d", PIPE_DLY, MAX_PIPE_DLY);
  end

  localparam logic [CNT_W-1:0] H_LAST       = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST       = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT_END    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_END    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] H_SYNC_START = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] H_SYNC_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] V_SYNC_START = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] V_SYNC_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  localparam sync_t SYNC_IDLE = '{hsync: ~SYNC_POL, vsync: ~SYNC_POL};

  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic             h_last;
  logic             v_last;
  logic             h_in_sync;
  logic             v_in_sync;
  logic             frame_wrap_q;
  sync_t            sync_raw_q;
  sync_t            sync_dly;

  assign h_last    = (h_cnt == H_LAST);
  assign v_last    = (v_cnt == V_LAST);
  assign h_in_sync = (h_cnt >= H_SYNC_START) && (h_cnt < H_SYNC_END);
  assign v_in_sync = (v_cnt >= V_SYNC_START) && (v_cnt < V_SYNC_END);

  // Pixel and line counters; the line counter advances on each pixel wrap.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_last) begin
      h_cnt <= '0;
      v_cnt <= v_last ? '0 : v_cnt + CNT_W'(1);
    end else begin
      h_cnt <= h_cnt + CNT_W'(1);
    end
  end

  // Registered raster outputs, one clock behind the counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x            <= '0;
      y            <= '0;
      frame_active <= 1'b0;
      frame_start  <= 1'b0;
      sync_raw_q   <= SYNC_IDLE;
    end else begin
      x                <= h_cnt;
      y                <= v_cnt;
      frame_active     <= (h_cnt < H_ACT_END) && (v_cnt < V_ACT_END);
      frame_start      <= (h_cnt == '0) && (v_cnt == '0);
      sync_raw_q.hsync <= h_in_sync ? SYNC_POL : ~SYNC_POL;
      sync_raw_q.vsync <= v_in_sync ? SYNC_POL : ~SYNC_POL;
    end
  end

  // Frame counter: the wrap is flagged one edge early so the count steps on the
  // same edge frame_start rises, and the frame right after reset reads 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_wrap_q <= 1'b0;
      frame_count  <= '0;
    end else begin
      frame_wrap_q <= h_last && v_last;
      if (frame_wrap_q) frame_count <= frame_count + 8'd1;
    end
  end

  sync_delay_line #(
    .WIDTH   (2),
    .DEPTH   (PIPE_DLY),
    .RST_VAL (SYNC_IDLE)
  ) u_sync_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (sync_raw_q),
    .dout  (sync_dly)
  );

  assign hsync = sync_dly.hsync;
  assign vsync = sync_dly.vsync;

endmodule
